pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage of the dynamically predicted pipeline. It drives the PC register's `pc_in` and hold inputs each cycle. It chooses between the following sources:
- sequential fetch
- BTB prediction
- EX-stage mispredict redirect
- interrupt vector
- interrupt return

It owns the interrupt entry/return state machine, the saved exception PC, the post-return interrupt guard, and the halt latch.

---
 rtl/pc_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller for the fetch stage. Each cycle it selects the value
// presented to the PC register (sequential, BTB prediction, EX redirect,
// interrupt vector, interrupt return) and decides whether the PC holds and
// whether the front-end pipeline registers are flushed. It also owns the
// interrupt entry/return state machine, the saved exception PC, the
// post-return interrupt guard and the halt latch.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   pc_cur                current PC register output
//   stall                 load-use stall from decode
//   pred_taken/target     BTB taken prediction for pc_cur
//   mispredict/redirect_pc EX-stage redirect request and correct PC
//   irq                   level-sensitive interrupt request
//   eret                  return-from-interrupt resolved in EX
//   halt_req              halt syscall resolved in EX
//   pc_next, pc_hold      to PC register (combinational)
//   flush                 kill IF/ID and ID/EX this cycle (combinational)
//   epc                   saved return address (registered)
//   in_handler, halted    state flags (registered)
//   irq_count             accepted interrupts, saturating (registered)

module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h0000_0040,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    input  logic        mispredict,
    input  logic [31:0] redirect_pc,
    input  logic        irq,
    input  logic        eret,
    input  logic        halt_req,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        flush,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        halted,
    output logic [7:0]  irq_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);

    // Saturating 8-bit increment for the interrupt counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

    logic [1:0]  state_r;
    logic [3:0]  guard_r;
    logic [1:0]  state_next_s;
    logic [3:0]  guard_next_s;
    logic [31:0] epc_next_s;
    logic [7:0]  count_next_s;
    logic        irq_ok_s;
    logic        eret_ok_s;
    logic        frozen_s;

    // Event qualifiers shared by PC selection, hold and state update.
    always_comb begin
        irq_ok_s  = irq & (state_r == ST_RUN) & (guard_r == 4'd0);
        eret_ok_s = eret & (state_r == ST_HANDLER);
        frozen_s  = (state_r == ST_HALTED) | halt_req;
    end

    // Priority selection of the next PC and the flush strobe.
    always_comb begin
        pc_next = pc_cur + 32'd4;
        flush   = 1'b0;
        if (rst) begin
            pc_next = RESET_VECTOR;
            flush   = 1'b1;
        end else if (frozen_s) begin
            pc_next = pc_cur;
            flush   = 1'b1;
        end else if (eret_ok_s) begin
            pc_next = epc;
            flush   = 1'b1;
        end else if (irq_ok_s) begin
            pc_next = IRQ_VECTOR;
            flush   = 1'b1;
        end else if (mispredict) begin
            pc_next = redirect_pc;
            flush   = 1'b1;
        end else if (stall) begin
            pc_next = pc_cur;
            flush   = 1'b0;
        end else if (pred_taken) begin
            pc_next = pred_target;
            flush   = 1'b0;
        end else begin
            pc_next = pc_cur + 32'd4;
            flush   = 1'b0;
        end
    end

    // PC hold: a stall only holds when no redirecting event overrides it.
    always_comb begin
        pc_hold = ~rst & (frozen_s | (stall & ~irq_ok_s & ~mispredict & ~eret_ok_s));
    end

    // Next-state logic for the interrupt/halt machine, guard, epc and counter.
    always_comb begin
        state_next_s = state_r;
        epc_next_s   = epc;
        count_next_s = irq_count;
        if (guard_r != 4'd0) begin
            guard_next_s = guard_r - 4'd1;
        end else begin
            guard_next_s = 4'd0;
        end

        if (halt_req) begin
            state_next_s = ST_HALTED;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (irq_ok_s) begin
                        // A redirect in the same cycle means pc_cur is a
                        // wrong-path address; resume at the corrected PC.
                        epc_next_s   = mispredict ? redirect_pc : pc_cur;
                        state_next_s = ST_HANDLER;
                        count_next_s = sat_inc8(irq_count);
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_HANDLER: begin
                    if (eret) begin
                        state_next_s = ST_RUN;
                        guard_next_s = GUARD_LOAD;
                    end else begin
                        state_next_s = ST_HANDLER;
                    end
                end
                ST_HALTED: begin
                    state_next_s = ST_HALTED;
                end
                default: begin
                    // Unreachable encoding: recover to a known state.
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    // State, guard and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            guard_r    <= 4'd0;
            epc        <= 32'd0;
            irq_count  <= 8'd0;
            in_handler <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            guard_r    <= guard_next_s;
            epc        <= epc_next_s;
            irq_count  <= count_next_s;
            in_handler <= (state_next_s == ST_HANDLER);
            halted     <= (state_next_s == ST_HALTED);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The bench plays the PC register
// (pc_cur follows pc_next unless pc_hold) and compares every cycle against a
// behavioural model of the selection rules and interrupt/halt bookkeeping.

module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] IV = 32'h0000_0040;
    localparam int          G  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        stall;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        irq;
    logic        eret;
    logic        halt_req;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        flush;
    logic [31:0] epc;
    logic        in_handler;
    logic        halted;
    logic [7:0]  irq_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_handler = 1'b0;
    logic        m_halted  = 1'b0;
    int          m_guard   = 0;
    logic [31:0] m_epc     = 32'd0;
    int          m_count   = 0;
    logic        regs_known = 1'b0;

    logic [31:0] cap_next;
    logic        cap_hold;
    logic        last_flush;

    pc_sequencer #(.RESET_VECTOR(RV), .IRQ_VECTOR(IV), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .irq(irq), .eret(eret), .halt_req(halt_req),
        .pc_next(pc_next), .pc_hold(pc_hold), .flush(flush),
        .epc(epc), .in_handler(in_handler), .halted(halted),
        .irq_count(irq_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; pred_taken = 1'b0; pred_target = 32'd0;
        mispredict = 1'b0; redirect_pc = 32'd0; irq = 1'b0; eret = 1'b0;
        halt_req = 1'b0;
    endtask

    // One clock cycle: check outputs at negedge, advance model and PC register.
    task automatic cycle();
        logic [31:0] e_next;
        logic        e_flush;
        logic        e_hold;
        logic        ok_irq;
        logic        ok_eret;
        @(negedge clk);
        ok_irq  = irq && !m_handler && !m_halted && (m_guard == 0);
        ok_eret = eret && m_handler;
        e_hold  = 1'b0;
        if (rst)                       begin e_next = RV;           e_flush = 1'b1; end
        else if (m_halted || halt_req) begin e_next = pc_cur;       e_flush = 1'b1; e_hold = 1'b1; end
        else if (ok_eret)              begin e_next = m_epc;        e_flush = 1'b1; end
        else if (ok_irq)               begin e_next = IV;           e_flush = 1'b1; end
        else if (mispredict)           begin e_next = redirect_pc;  e_flush = 1'b1; end
        else if (stall)                begin e_next = pc_cur;       e_flush = 1'b0; e_hold = 1'b1; end
        else if (pred_taken)           begin e_next = pred_target;  e_flush = 1'b0; end
        else                           begin e_next = pc_cur + 32'd4; e_flush = 1'b0; end

        check_val("pc_next", pc_next, e_next);
        check_val("flush", flush, e_flush);
        check_val("pc_hold", pc_hold, e_hold);
        if (regs_known) begin
            check_val("epc", epc, m_epc);
            check_val("in_handler", in_handler, m_handler);
            check_val("halted", halted, m_halted);
            check_val("irq_count", irq_count, m_count);
        end
        cap_next   = pc_next;
        cap_hold   = pc_hold;
        last_flush = flush;

        if (rst) begin
            m_handler = 1'b0; m_halted = 1'b0; m_guard = 0; m_epc = 32'd0; m_count = 0;
            regs_known = 1'b1;
        end else begin
            if (m_guard > 0) m_guard = m_guard - 1;
            if (halt_req) begin
                m_halted = 1'b1; m_handler = 1'b0;
            end else if (m_halted) begin
                m_halted = 1'b1;
            end else if (ok_eret) begin
                m_handler = 1'b0; m_guard = G;
            end else if (ok_irq) begin
                m_epc = mispredict ? redirect_pc : pc_cur;
                m_handler = 1'b1;
                m_count = (m_count < 255) ? m_count + 1 : 255;
            end
        end
        @(posedge clk);
        #1;
        pc_cur = cap_hold ? pc_cur : cap_next;
    endtask

    initial begin
        idle();
        pc_cur = 32'hDEAD_BEEF;
        #1;

        // Reset, then free-running sequential fetch and a BTB hit
        rst = 1'b1; cycle(); cycle(); rst = 1'b0;
        check_val("reset_pc", pc_cur, 32'h0);
        check_val("reset_halted", halted, 1'b0);
        cycle(); check_val("seq_4", pc_cur, 32'h4);
        cycle(); check_val("seq_8", pc_cur, 32'h8);
        pred_taken = 1'b1; pred_target = 32'h100;
        cycle(); check_val("btb_pc", pc_cur, 32'h100);
        check_val("btb_flush", last_flush, 1'b0);
        idle();

        // Stall for three cycles, then mispredict while still stalled
        mispredict = 1'b1; redirect_pc = 32'h20; cycle(); idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(); check_val("stall_hold", pc_cur, 32'h20);
        end
        mispredict = 1'b1; redirect_pc = 32'h80;
        cycle(); check_val("redir_pc", pc_cur, 32'h80);
        check_val("redir_flush", last_flush, 1'b1);
        idle();
        cycle(); check_val("redir_flush_once", last_flush, 1'b0);
        check_val("after_redir", pc_cur, 32'h84);

        // Interrupt together with a stall
        mispredict = 1'b1; redirect_pc = 32'h30; cycle(); idle();
        irq = 1'b1; stall = 1'b1;
        cycle();
        check_val("irq_pc", pc_cur, 32'h40);
        check_val("irq_epc", epc, 32'h30);
        check_val("irq_in_handler", in_handler, 1'b1);
        check_val("irq_count1", irq_count, 8'd1);
        check_val("irq_flush", last_flush, 1'b1);
        stall = 1'b0;

        // irq held through the handler and the guard window
        cycle(); check_val("no_nest_pc", pc_cur, 32'h44);
        check_val("no_nest_cnt", irq_count, 8'd1);
        eret = 1'b1;
        cycle(); check_val("eret_pc", pc_cur, 32'h30);
        check_val("eret_run", in_handler, 1'b0);
        eret = 1'b0;
        cycle(); check_val("guard1_pc", pc_cur, 32'h34);
        check_val("guard1_state", in_handler, 1'b0);
        cycle(); check_val("guard2_pc", pc_cur, 32'h38);
        check_val("guard2_state", in_handler, 1'b0);
        cycle(); check_val("guard_end_pc", pc_cur, 32'h40);
        check_val("guard_end_state", in_handler, 1'b1);
        check_val("irq_count2", irq_count, 8'd2);

        // Interrupt accepted in the same cycle as a mispredict
        irq = 1'b0; eret = 1'b1; cycle(); eret = 1'b0;
        cycle(); cycle();
        irq = 1'b1; mispredict = 1'b1; redirect_pc = 32'h90;
        cycle(); check_val("irq_mis_epc", epc, 32'h90);
        check_val("irq_mis_pc", pc_cur, 32'h40);
        idle();

        // Halt together with a mispredict, then only reset leaves HALTED
        halt_req = 1'b1; mispredict = 1'b1; redirect_pc = 32'h200;
        cycle(); check_val("halt_pc", pc_cur, 32'h40);
        check_val("halt_flag", halted, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) begin
            irq = 1'($urandom_range(0, 1)); eret = 1'($urandom_range(0, 1));
            mispredict = 1'($urandom_range(0, 1)); redirect_pc = $urandom();
            cycle(); check_val("halt_frozen", pc_cur, 32'h40);
            check_val("halt_stays", halted, 1'b1);
        end
        idle(); rst = 1'b1;
        cycle(); rst = 1'b0;
        check_val("rst_pc", pc_cur, 32'h0);
        check_val("rst_halted", halted, 1'b0);
        check_val("rst_epc", epc, 32'h0);
        check_val("rst_count", irq_count, 8'd0);

        // Drive irq/eret round trips until the counter saturates
        for (int i = 0; i < 1100; i++) begin
            irq = 1'b1; eret = m_handler;
            cycle();
        end
        check_val("count_sat", irq_count, 8'd255);
        idle(); rst = 1'b1; cycle(); rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            halt_req    = ($urandom_range(0, 99) == 0);
            irq         = ($urandom_range(0, 3) == 0);
            eret        = ($urandom_range(0, 5) == 0);
            mispredict  = ($urandom_range(0, 7) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            pred_taken  = ($urandom_range(0, 3) == 0);
            pred_target = $urandom();
            redirect_pc = $urandom();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
